// File: rtl/morphle_pkg.sv
// Shared constants for the Morphle Logic fabric.
// Holds cell config codes, dual-rail encodings, helper function.
package morphle_pkg;

    // Cell configuration codes, 3 bits per cell
    localparam logic [2:0] CFG_EMPTY = 3'b000;
    localparam logic [2:0] CFG_PLUS  = 3'b001;
    localparam logic [2:0] CFG_H     = 3'b010;
    localparam logic [2:0] CFG_V     = 3'b011;
    localparam logic [2:0] CFG_ONE   = 3'b100;
    localparam logic [2:0] CFG_ZERO  = 3'b101;
    localparam logic [2:0] CFG_Y     = 3'b110;
    localparam logic [2:0] CFG_N     = 3'b111;

    // Dual-rail data encoding; 2'b11 is illegal
    localparam logic [1:0] DR_EMPTY = 2'b00;
    localparam logic [1:0] DR_ZERO  = 2'b01;
    localparam logic [1:0] DR_ONE   = 2'b10;

    // Illegal code collapses to empty
    function automatic logic [1:0] dr_norm(
        input logic [1:0] x
    );
        return (x == 2'b11) ? DR_EMPTY : x;
    endfunction

endpackage

// File: rtl/morphle_la_fabric_if.sv
// Wishbone slave bus bundle for the fabric top.
// master drives stb/cyc/we/sel/dat_i/adr; slave drives ack/dat_o.
interface morphle_la_fabric_if;

    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i,
        output wbs_cyc_i,
        output wbs_we_i,
        output wbs_sel_i,
        output wbs_dat_i,
        output wbs_adr_i,
        input  wbs_ack_o,
        input  wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i,
        input  wbs_cyc_i,
        input  wbs_we_i,
        input  wbs_sel_i,
        input  wbs_dat_i,
        input  wbs_adr_i,
        output wbs_ack_o,
        output wbs_dat_o
    );

endinterface

// File: rtl/morphle_yblock.sv
// Self-timed Morphle Logic cell array with edge tie-offs.
// Ports: i_confclk/i_cbit config shift in, i_rst fabric reset,
// i_top dual-rail top data, o_bot bottom data, o_cbit chain out.
module morphle_yblock
    import morphle_pkg::*;
#(
    parameter int BLOCKWIDTH  = 16,
    parameter int BLOCKHEIGHT = 16
) (
    input  logic                    i_confclk,
    input  logic                    i_rst,
    input  logic [BLOCKWIDTH-1:0]   i_cbit,
    input  logic [2*BLOCKWIDTH-1:0] i_top,
    output logic [BLOCKWIDTH-1:0]   o_cbit,
    output logic [2*BLOCKWIDTH-1:0] o_bot
);

    localparam int W = BLOCKWIDTH;
    localparam int H = BLOCKHEIGHT;

    // Each cell keeps its neighbour links as its own nets so the
    // vertical, ack and horizontal chains stay acyclic per signal.
    for (genvar r = 0; r < H; r++) begin : g_row
        for (genvar c = 0; c < W; c++) begin : g_col
            logic [2:0] r_cfg;
            logic [1:0] r_vq;
            logic       w_cin;
            logic       w_ack;
            logic       w_cons;
            logic [1:0] w_hl;
            logic [1:0] w_hr;
            logic [1:0] w_h;
            logic [1:0] vs;
            logic [1:0] vb;
            logic [1:0] hs;
            logic [1:0] hb;
            logic       he;
            logic       ve;
            logic       w_unused;

            if (r == 0) begin : g_ti
                assign vs    = i_top[2*c +: 2];
                assign w_cin = i_cbit[c];
            end else begin : g_ti
                assign vs    = g_row[r-1].g_col[c].r_vq;
                assign w_cin = g_row[r-1].g_col[c].r_cfg[2];
            end

            // Bottom consumer is permanently empty-ready
            if (r == H - 1) begin : g_bi
                assign w_ack = 1'b1;
            end else begin : g_bi
                assign w_ack = g_row[r+1].g_col[c].ve;
            end

            if (c == 0) begin : g_li
                assign w_hl = DR_EMPTY;
            end else begin : g_li
                assign w_hl = g_row[r].g_col[c-1].hs;
            end

            if (c == W - 1) begin : g_ri
                assign w_hr = DR_EMPTY;
            end else begin : g_ri
                assign w_hr = g_row[r].g_col[c+1].hb;
            end

            // Config chain: cfg[2] feeds the row below
            always_ff @(posedge i_confclk) begin
                r_cfg <= {r_cfg[1:0], w_cin};
            end

            always_comb begin
                vb     = DR_EMPTY;
                hs     = DR_EMPTY;
                hb     = DR_EMPTY;
                w_cons = 1'b0;
                w_h    = dr_norm(dr_norm(w_hl) | dr_norm(w_hr));
                case (r_cfg)
                    CFG_PLUS: begin
                        vb     = dr_norm(vs);
                        hs     = dr_norm(w_hl);
                        hb     = dr_norm(w_hr);
                        w_cons = 1'b1;
                    end
                    CFG_H: begin
                        hs = dr_norm(w_hl);
                        hb = dr_norm(w_hr);
                    end
                    CFG_V: begin
                        vb     = dr_norm(vs);
                        w_cons = 1'b1;
                    end
                    CFG_ONE:  vb = DR_ONE;
                    CFG_ZERO: vb = DR_ZERO;
                    CFG_Y: begin
                        vb     = (w_h == DR_ONE) ?
                                 dr_norm(vs) : DR_EMPTY;
                        w_cons = 1'b1;
                    end
                    CFG_N: begin
                        vb     = (w_h == DR_ZERO) ?
                                 dr_norm(vs) : DR_EMPTY;
                        w_cons = 1'b1;
                    end
                    default: ;
                endcase
            end

            assign he = (w_h == DR_EMPTY);

            // Cells that ignore their vertical input never stall
            // the producer above them.
            assign ve = w_cons ? w_ack : 1'b1;

            // Muller-style hold: follows vb while the consumer is
            // empty-ready, holds otherwise; fabric reset empties it.
            always_latch begin
                if (i_rst) begin
                    r_vq <= DR_EMPTY;
                end else if (w_ack) begin
                    r_vq <= vb;
                end
            end

            // he is a debug-only probe
            assign w_unused = he;
        end
    end

    for (genvar c = 0; c < W; c++) begin : g_out
        assign o_bot[2*c +: 2] = g_row[H-1].g_col[c].r_vq;
        assign o_cbit[c]       = g_row[H-1].g_col[c].r_cfg[2];
    end

endmodule

// File: rtl/morphle_la_fabric.sv
// Caravel user-project top: LA-driven Morphle fabric, inert WB/GPIO.
// Ports: wb_clk_i/wb_rst_i (active-low sync), wbs bus, la_*, io_*.
module morphle_la_fabric
    import morphle_pkg::*;
#(
    parameter int BLOCKWIDTH  = 16,
    parameter int BLOCKHEIGHT = 16
) (
`ifdef USE_POWER_PINS
    input  logic          vdda1,
    input  logic          vdda2,
    input  logic          vssa1,
    input  logic          vssa2,
    input  logic          vccd1,
    input  logic          vccd2,
    input  logic          vssd1,
    input  logic          vssd2,
`endif
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    morphle_la_fabric_if.slave wbs,
    input  logic [127:0]  la_data_in,
    output logic [127:0]  la_data_out,
    output logic [127:0]  la_oen,
    input  logic [37:0]   io_in,
    output logic [37:0]   io_out,
    output logic [37:0]   io_oeb
);

    localparam int W = BLOCKWIDTH;

    logic             r_ack;
    logic             w_frst;
    logic             w_confclk;
    logic [W-1:0]     w_cbitin;
    logic [W-1:0]     w_cbitout;
    logic [2*W-1:0]   w_top;
    logic [2*W-1:0]   w_bot;
    logic             w_unused;

    // One-cycle ack per request; never back-to-back
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            r_ack <= 1'b0;
        end else begin
            r_ack <= wbs.wbs_stb_i & wbs.wbs_cyc_i & ~r_ack;
        end
    end

    assign wbs.wbs_ack_o = r_ack;
    assign wbs.wbs_dat_o = '0;

    assign w_frst    = la_data_in[113];
    assign w_confclk = la_data_in[112];
    assign w_cbitin  = la_data_in[96 +: W];
    assign w_top     = la_data_in[64 +: 2*W];

    morphle_yblock #(
        .BLOCKWIDTH  (BLOCKWIDTH),
        .BLOCKHEIGHT (BLOCKHEIGHT)
    ) u_yblock (
        .i_confclk (w_confclk),
        .i_rst     (w_frst),
        .i_cbit    (w_cbitin),
        .i_top     (w_top),
        .o_cbit    (w_cbitout),
        .o_bot     (w_bot)
    );

    always_comb begin
        la_data_out            = '0;
        la_data_out[32 +: W]   = w_cbitout;
        la_data_out[0 +: 2*W]  = w_bot;
    end

    assign la_oen = {{64{1'b1}}, {64{1'b0}}};
    assign io_out = '0;
    assign io_oeb = '1;

    assign w_unused = &{1'b0,
                        la_data_in[127:114],
                        la_data_in[63:0],
                        io_in,
                        wbs.wbs_we_i,
                        wbs.wbs_sel_i,
                        wbs.wbs_dat_i,
                        wbs.wbs_adr_i};

`ifdef USE_POWER_PINS
    logic w_unused_pwr;
    assign w_unused_pwr = &{1'b0, vdda1, vdda2, vssa1, vssa2,
                            vccd1, vccd2, vssd1, vssd2};
`endif

endmodule

// File: tb/tb_morphle_la_fabric.sv
// Scoreboard bench for morphle_la_fabric.
// Expectations are queued at drive time and drained on sampling.
module tb_morphle_la_fabric;

    logic         wb_clk_i = 1'b0;
    logic         wb_rst_i = 1'b0;
    logic [127:0] la_data_in;
    logic [127:0] la_data_out;
    logic [127:0] la_oen;
    logic [37:0]  io_in;
    logic [37:0]  io_out;
    logic [37:0]  io_oeb;

    morphle_la_fabric_if wb ();

    morphle_la_fabric dut (
`ifdef USE_POWER_PINS
        .vdda1       (1'b1),
        .vdda2       (1'b1),
        .vssa1       (1'b0),
        .vssa2       (1'b0),
        .vccd1       (1'b1),
        .vccd2       (1'b1),
        .vssd1       (1'b0),
        .vssd2       (1'b0),
`endif
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .wbs         (wb),
        .la_data_in  (la_data_in),
        .la_data_out (la_data_out),
        .la_oen      (la_oen),
        .io_in       (io_in),
        .io_out      (io_out),
        .io_oeb      (io_oeb)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        string        tag;
        int           sel;
        logic [127:0] exp;
    } sb_t;

    sb_t sbq[$];
    int  n_chk  = 0;
    int  n_pass = 0;

    task automatic check(input string tag,
                         input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] obs(input int sel);
        logic [127:0] v;
        v = '0;
        case (sel)
            0: v[31:0]  = la_data_out[31:0];
            1: v[15:0]  = la_data_out[47:32];
            2: v[79:0]  = la_data_out[127:48];
            3: v[0]     = wb.wbs_ack_o;
            4: v[31:0]  = wb.wbs_dat_o;
            5: v[37:0]  = io_oeb;
            6: v[37:0]  = io_out;
            7: v        = la_oen;
            default: v  = '0;
        endcase
        return v;
    endfunction

    task automatic expect_val(input string tag,
                              input int sel,
                              input logic [127:0] v);
        sb_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sbq.push_back(e);
    endtask

    task automatic drain();
        sb_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            check(e.tag, obs(e.sel), e.exp);
        end
    endtask

    task automatic settle();
        #3;
        drain();
    endtask

    // Dual-rail model: illegal pairs read as empty
    function automatic logic [31:0] dr_clean(input logic [31:0] x);
        logic [31:0] y;
        y = x;
        for (int i = 0; i < 16; i++) begin
            if (x[2*i +: 2] == 2'b11) y[2*i +: 2] = 2'b00;
        end
        return y;
    endfunction

    function automatic logic [47:0] image(input logic [2:0] rest,
                                          input logic [2:0] last);
        return {last, {15{rest}}};
    endfunction

    task automatic conf_edge(input logic [15:0] bits);
        la_data_in[111:96] = bits;
        #2;
        la_data_in[112] = 1'b1;
        #3;
        la_data_in[112] = 1'b0;
        #2;
    endtask

    task automatic load(input logic [47:0] img);
        for (int s = 0; s < 48; s++) begin
            conf_edge({16{img[47-s]}});
        end
    endtask

    task automatic set_top(input logic [31:0] v);
        la_data_in[95:64] = v;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] t;

        la_data_in      = '0;
        la_data_in[113] = 1'b1;
        io_in           = '0;
        wb.wbs_stb_i    = 1'b1;
        wb.wbs_cyc_i    = 1'b1;
        wb.wbs_we_i     = 1'b0;
        wb.wbs_sel_i    = '0;
        wb.wbs_dat_i    = '0;
        wb.wbs_adr_i    = '0;

        repeat (2) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        expect_val("ack_rst", 3, 128'd0);
        expect_val("dat_o", 4, 128'd0);
        expect_val("io_oeb", 5, {90'd0, 38'h3F_FFFF_FFFF});
        expect_val("io_out", 6, 128'd0);
        expect_val("la_oen", 7, {{64{1'b1}}, 64'd0});
        drain();

        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        expect_val("ack_hi", 3, 128'd1);
        drain();
        @(negedge wb_clk_i);
        expect_val("ack_lo", 3, 128'd0);
        drain();
        wb.wbs_stb_i = 1'b0;
        wb.wbs_cyc_i = 1'b0;
        @(negedge wb_clk_i);
        expect_val("ack_idle", 3, 128'd0);
        drain();

        // All '|' under fabric reset, then release
        load(image(3'b011, 3'b011));
        la_data_in[113] = 1'b0;
        set_top(32'h6666_9999);
        expect_val("vpass", 0, 128'h6666_9999);
        expect_val("la_hi0", 2, 128'd0);
        expect_val("cbo_v", 1, 128'd0);
        settle();

        set_top(32'hFFFF_FFFF);
        expect_val("illegal", 0, 128'd0);
        settle();

        for (int i = 0; i < 6; i++) begin
            t = $urandom;
            set_top(t);
            expect_val("vrand", 0, {96'd0, dr_clean(t)});
            settle();
        end

        set_top(32'h6666_9999);
        #3;
        la_data_in[113] = 1'b1;
        expect_val("frst_on", 0, 128'd0);
        settle();
        set_top(32'h5555_5555);
        la_data_in[113] = 1'b0;
        expect_val("frst_off", 0, 128'h5555_5555);
        settle();

        load(image(3'b001, 3'b001));
        set_top(32'h9999_6666);
        expect_val("plus", 0, 128'h9999_6666);
        settle();

        load(image(3'b010, 3'b010));
        expect_val("hbar", 0, 128'd0);
        settle();

        load(48'd0);
        set_top(32'hAAAA_AAAA);
        expect_val("dots", 0, 128'd0);
        settle();

        set_top(32'h0);
        load(image(3'b011, 3'b100));
        expect_val("src1", 0, 128'hAAAA_AAAA);
        expect_val("cbo_1", 1, 128'hFFFF);
        settle();
        set_top(32'h5555_5555);
        expect_val("src1_in", 0, 128'hAAAA_AAAA);
        settle();

        set_top(32'h0);
        load(image(3'b011, 3'b101));
        expect_val("src0", 0, 128'h5555_5555);
        expect_val("cbo_0", 1, 128'hFFFF);
        settle();

        set_top(32'h5555_5555);
        load(image(3'b011, 3'b110));
        expect_val("ycell", 0, 128'd0);
        settle();
        load(image(3'b011, 3'b111));
        expect_val("ncell", 0, 128'd0);
        settle();

        // Chain latency: a single pushed bit needs 48 edges
        load(48'd0);
        conf_edge(16'hFFFF);
        expect_val("chain_1", 1, 128'd0);
        drain();
        for (int i = 2; i <= 48; i++) begin
            conf_edge(16'h0000);
            expect_val($sformatf("chain_%0d", i), 1,
                       (i == 48) ? 128'hFFFF : 128'd0);
            drain();
        end
        conf_edge(16'h0000);
        expect_val("chain_49", 1, 128'd0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
